// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_responder data-memory responder.
package dmem_pkg;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned BE_W   = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   // Replace only the byte lanes whose enable bit is set.
   function automatic logic [WORD_W-1:0] be_merge(
      input logic [WORD_W-1:0] old_w,
      input logic [WORD_W-1:0] new_w,
      input logic [BE_W-1:0]   be
   );
      logic [WORD_W-1:0] merged;
      merged = old_w;
      for (int unsigned i = 0; i < BE_W; i++) begin
         if (be[i]) merged[8*i +: 8] = new_w[8*i +: 8];
      end
      return merged;
   endfunction
endpackage

// File: rtl/dmem_array.sv
// Word array with byte-strobed synchronous write and a registered, clearable read port.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned ADDR_W      = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic              i_re,
   input  logic              i_clr,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic [BE_W-1:0]   i_be,
   output logic [WORD_W-1:0] o_rdata
);
   logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
   logic [WORD_W-1:0] r_rdata;

   // Storage is deliberately outside the reset domain; contents survive rst.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= be_merge(r_mem[i_addr], i_wdata, i_be);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       r_rdata <= '0;
      else if (i_clr) r_rdata <= '0;
      else if (i_re)  r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with wait-state latency.
// Optional misaligned-address rejection: define DMEM_MISALIGN_CHECK_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err
);
   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t            r_state, w_next;
   logic [3:0]        r_wcnt;
   logic              r_we;
   logic [29:0]       r_widx;
   logic [WORD_W-1:0] r_wdata;
   logic [BE_W-1:0]   r_be;
   logic              r_err;

   logic              w_accept, w_hs, w_in_range, w_misalign, w_ok;
   logic              w_mem_we, w_mem_re, w_mem_clr;

`ifdef DMEM_MISALIGN_CHECK_EN
   logic [1:0]        r_alo;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          r_alo <= '0;
      else if (r_state == S_IDLE && req_valid) r_alo <= req_addr[1:0];
   end
   assign w_misalign = (r_alo != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   // Compare the full 30-bit index so high addresses are rejected, never wrapped.
   assign w_in_range = ({2'b00, r_widx} < 32'(DEPTH_WORDS));
   assign w_ok       = w_in_range && !w_misalign;

   assign w_accept  = (r_state == S_IDLE) && req_valid;
   assign w_hs      = (r_state == S_RESP) && rsp_ready;
   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_err   = r_err;

   assign w_mem_we  = (r_state == S_ACCESS) && w_ok && r_we;
   assign w_mem_re  = (r_state == S_ACCESS) && w_ok && !r_we;
   assign w_mem_clr = ((r_state == S_ACCESS) && !(w_ok && !r_we)) || w_hs;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (req_valid) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
         S_WAIT:   if (r_wcnt == 4'd0) w_next = S_ACCESS;
         S_ACCESS: w_next = S_RESP;
         S_RESP:   if (rsp_ready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wcnt  <= '0;
         r_we    <= 1'b0;
         r_widx  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wcnt  <= WAIT_LOAD;
            r_we    <= req_we;
            r_widx  <= req_addr[31:2];
            r_wdata <= req_wdata;
            r_be    <= req_be;
         end else if (r_state == S_WAIT && r_wcnt != 4'd0) begin
            r_wcnt <= r_wcnt - 4'd1;
         end
         if (r_state == S_ACCESS) r_err <= !w_ok;
         else if (w_hs)           r_err <= 1'b0;
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (AW)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_mem_we),
      .i_re    (w_mem_re),
      .i_clr   (w_mem_clr),
      .i_addr  (r_widx[AW-1:0]),
      .i_wdata (r_wdata),
      .i_be    (r_be),
      .o_rdata (rsp_rdata)
   );
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH_WORDS=1024, WAIT_CYCLES=2).
module tb_dmem_responder;
   localparam int unsigned DEPTH = 1024;
   localparam int          LAT   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
   logic [31:0] rsp_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] model [0:DEPTH-1];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t tbl [14];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: memory is an array of words; out-of-range or (optionally) misaligned requests error out.
   task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] rd, output logic er);
      int unsigned w;
      logic misal;
      w = addr / 4;
      misal = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
      misal = (addr % 4) != 0;
`endif
      rd = '0;
      er = 1'b0;
      if (w >= DEPTH || misal) er = 1'b1;
      else if (we) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) model[w][8*b +: 8] = wdata[8*b +: 8];
      end else rd = model[w];
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
      int k;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      rsp_ready = 1'b1;
      k = 0;
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("accept_timeout", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      // Scramble request fields after the accept edge; they must be ignored.
      req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom;
      req_wdata = $urandom; req_be = 4'($urandom_range(0, 15));
      wait_rsp(lat);
      rd = rsp_rdata;
      er = rsp_err;
      @(posedge clk); #1;
      chk("rsp_valid_clear", {31'd0, rsp_valid}, 32'd0);
      chk("rsp_rdata_clear", rsp_rdata, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd, erd, rd1, rd2;
      logic        er, eer, er1, er2;
      int          lat;
      string       nm;

      tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      tbl[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0,        1'b0};
      tbl[3]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
      tbl[4]  = '{1'b0, 32'h20,       32'h0,        4'hF, 32'h11BB33DD, 1'b0};
      tbl[5]  = '{1'b1, 32'h0,        32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
      tbl[6]  = '{1'b0, 32'h1000,     32'h0,        4'hF, 32'h0,        1'b1};
      tbl[7]  = '{1'b1, 32'h1000,     32'h12345678, 4'hF, 32'h0,        1'b1};
      tbl[8]  = '{1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
      tbl[9]  = '{1'b1, 32'h24,       32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
      tbl[10] = '{1'b0, 32'h24,       32'h0,        4'h0, 32'h0,        1'b0};
`ifdef DMEM_MISALIGN_CHECK_EN
      tbl[11] = '{1'b1, 32'h12,       32'h55667788, 4'hF, 32'h0,        1'b1};
      tbl[12] = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
`else
      tbl[11] = '{1'b1, 32'h12,       32'h55667788, 4'hF, 32'h0,        1'b0};
      tbl[12] = '{1'b0, 32'h10,       32'h0,        4'h0, 32'h55667788, 1'b0};
`endif
      tbl[13] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
      rst = 1'b1;

      // Give the first 32 words known contents
      for (int i = 0; i < 32; i++) begin
         model_txn(1'b1, 32'(i * 4), 32'h0, 4'hF, erd, eer);
         txn(1'b1, 32'(i * 4), 32'h0, 4'hF, rd, er, lat);
         chk("init_err", {31'd0, er}, 32'd0);
      end

      for (int i = 0; i < 14; i++) begin
         model_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, erd, eer);
         txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er, lat);
         nm = $sformatf("vec%0d", i);
         chk({nm, "_rdata"}, rd, tbl[i].exp_rd);
         chk({nm, "_err"}, {31'd0, er}, {31'd0, tbl[i].exp_err});
         chk({nm, "_lat"}, 32'(lat), 32'(LAT));
      end

      // Backpressure: response held 5 cycles while a second request waits
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF; rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_addr = 32'h20;
      model_txn(1'b0, 32'h10, 32'h0, 4'h0, rd1, er1);
      model_txn(1'b0, 32'h20, 32'h0, 4'h0, rd2, er2);
      wait_rsp(lat);
      chk("bp_lat", 32'(lat), 32'(LAT));
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_rdata", rsp_rdata, rd1);
         chk("bp_err", {31'd0, rsp_err}, {31'd0, er1});
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("bp_hs_req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      chk("bp_second_accepted", {31'd0, req_ready}, 32'd0);
      req_valid = 1'b0;
      wait_rsp(lat);
      chk("bp2_lat", 32'(lat), 32'(LAT));
      chk("bp2_rdata", rsp_rdata, rd2);
      @(posedge clk); #1;

      // Reset during WAIT of a write: no write must happen
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rstw_rsp_rdata", rsp_rdata, 32'd0);
      chk("rstw_rsp_err",   {31'd0, rsp_err}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      model_txn(1'b0, 32'h40, 32'h0, 4'h0, erd, eer);
      txn(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
      chk("rstw_read_0x40", rd, erd);
      chk("rstw_read_0x40_val", rd, 32'h0);

      // Randomized traffic against the reference model
      for (int i = 0; i < 200; i++) begin
         logic        we;
         logic [31:0] addr, wdata;
         logic [3:0]  be;
         we    = 1'($urandom_range(0, 1));
         wdata = $urandom;
         be    = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0)
            addr = 32'h1000 + ($urandom % 32'hFFFF0000);
         else
            addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
         model_txn(we, addr, wdata, be, erd, eer);
         txn(we, addr, wdata, be, rd, er, lat);
         chk("rnd_rdata", rd, erd);
         chk("rnd_err", {31'd0, er}, {31'd0, eer});
         chk("rnd_lat", 32'(lat), 32'(LAT));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
